md5_crack_scheduler: RTL and testbench
======================================

# md5_crack_scheduler

Sequences a bank of N pipelined `md5` cores through a brute-force search of 8-digit ASCII decimal passwords, from "00000000" up to a configurable last candidate. Every RUN cycle it issues N consecutive candidates, one per core. It qualifies each core's hash output with an internal valid pipeline and compares it against the target hash. It reports the first match, or exhaustion, plus an elapsed cycle count. It sits between the top-level button/LCD FSM and the `md5` instances, and replaces ad-hoc per-core attempt registers in the top level.

## Interface
- `N_CORES`, 3: number of `md5` cores driven; valid range 1..9.
- `PIPE_LAT`, 64: `md5` latency, in cycles, from `att` to `hash`/`current_att`.
- `LAST_CAND`, "99999999": last candidate searched (64-bit ASCII).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle pulse; begins a search from "00000000".
- `abort` input 1: returns to IDLE; has priority over `start` and over a match.
- `target_hash` input 128: target digest; sampled on `start`.
- `att_bus` output 64*N_CORES: candidate for core i on `[64*i +: 64]`; registered.
- `hash_bus` input 128*N_CORES: core i digest.
- `ret_att_bus` input 64*N_CORES: core i `current_att`.
- `busy` output 1: high in RUN or DRAIN.
- `found` output 1: high in FOUND.
- `exhausted` output 1: high in EXHAUSTED.
- `password` output 64: the matching candidate; latched.
- `cycles` output 32: number of RUN+DRAIN cycles; freezes when the search ends.

## Operation
- **States:**
  - IDLE: on `start`, go to RUN.
  - RUN: on a qualified match, go to FOUND. When the group containing LAST_CAND has been issued, go to DRAIN.
  - DRAIN: on a qualified match, go to FOUND. After PIPE_LAT cycles with no match, go to EXHAUSTED.
  - FOUND / EXHAUSTED: on `start`, go to RUN (fresh search). Otherwise hold.
  - Any state: `abort` goes to IDLE.
- **Candidate generator:**
  - `base` is an 8-digit ASCII BCD counter, low nibble per byte, carry-ripple.
  - Core i gets `base + i`.
  - `base` advances by N_CORES per RUN cycle; digit carry is handled per byte.
  - Candidates greater than LAST_CAND are masked: their valid bit is 0 and `att` is don't-care.
- **Valid pipeline:** a PIPE_LAT-deep shift register with N_CORES bits per stage. Bit i at the tap qualifies `hash_bus[i]` in that cycle. The pipeline is cleared on `reset`, `abort` and `start`.
- **Compare:** a match requires tap bit i = 1 AND `hash_bus[i] == target_hash_q`. Unqualified hashes are ignored.
- **Simultaneous matches:** the lowest core index wins, i.e. the smallest candidate. `password` takes `ret_att_bus[i]` of the winner.
- **On FOUND:** issuing stops. `att_bus` holds its last value. Later tap outputs are ignored.
- **`start` in RUN/DRAIN:** ignored.
- **`abort` coinciding with a match:** go to IDLE; `found` stays 0.
- **`cycles`:** increments in RUN and DRAIN and saturates at 0xFFFFFFFF. It is zeroed on `start`, held in FOUND/EXHAUSTED, and zeroed in IDLE.

## Timing
- **Reset values:**
  - State is IDLE; `busy`, `found`, `exhausted` are 0.
  - `password` is 64'h0 and `cycles` is 0.
  - `att_bus` is all "00000000"; the valid pipeline is all 0.
- **Start:**
  - `start` is seen at edge t.
  - RUN is entered and group 0 ("00000000".."0000000(N-1)") appears on `att_bus` after t+1. Group k appears after t+1+k.
- **Qualification:** a candidate on `att_bus` in cycle c is qualified at the compare in cycle c+PIPE_LAT.
- **Match:** a match compared in cycle m gives `found` = 1 and a valid `password` from cycle m+1.
- **Exhaustion:** the last group is issued in cycle L; `exhausted` rises in cycle L+PIPE_LAT+1.
- **Status flags:** all registered; no combinational paths from inputs to outputs.

## Structure
- **Shared package `md5_pkg`:**
  - Digest width 128 and candidate width 64.
  - ASCII "0" constant.
  - The state enum (IDLE/RUN/DRAIN/FOUND/EXHAUSTED).
  - Default PIPE_LAT.
- **Sub-module `bcd_ascii_adder`:** combinational; adds a 0..9 increment to an 8-digit ASCII number. It is instantiated per core for `base + i`, and once for `base + N_CORES`.
- **In the top level:** the `md5` cores and the LCD formatting (ms conversion of `cycles`) stay outside this block.

## Test plan
- **Early match:** bench uses a behavioural md5 model with latency PIPE_LAT=64, N_CORES=3, target = md5("00000005"). Required: `found` goes high 1+1+64+1 cycles after `start`; `password` = "00000005"; `cycles` = 66.
- **Exhaustion:** LAST_CAND = "00000007", target not in the range, N=3. Required: groups 0-2, 3-5 and 6-7 are issued, with "00000008" masked; `exhausted` is high PIPE_LAT+1 cycles after the third group; `found` = 0.
- **Digit carry:** N=3, observe the issue sequence around "00000099". Required: it reads "00000099", "00000100", "00000101"; there is never a ":" (0x3A) byte.
- **Simultaneous match:** the model returns the target digest for both core 0 and core 2 in the same cycle. Required: `password` = the core-0 candidate.
- **Abort mid-run:** `abort` is asserted 10 cycles into RUN while a match is in flight. Required: IDLE next cycle; `busy` = 0; `found` never asserts; a subsequent `start` restarts from "00000000" with `cycles` = 0.
- **Reset in DRAIN:** `reset` is asserted during DRAIN. Required: all outputs are at their reset values on the next cycle; garbage on `hash_bus` afterwards produces no match.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared definitions for the md5 brute-force search block.
// Holds the digest/candidate widths, the ASCII digit base, the scheduler
// state enum and the default md5 core latency.
package md5_pkg;
  localparam int DIGEST_W         = 128;
  localparam int CAND_W           = 64;
  localparam int DEFAULT_PIPE_LAT = 64;

  localparam logic [7:0]        ASCII_ZERO    = 8'h30;
  localparam logic [CAND_W-1:0] ALL_ZERO_CAND = {8{ASCII_ZERO}};

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FOUND,
    EXHAUSTED
  } sched_state_t;
endpackage

// File: rtl/md5_crack_scheduler_if.sv
// Bus between the search scheduler and its bank of md5 cores.
//   att_bus     : candidate per core, 64 bits per core (scheduler -> cores)
//   hash_bus    : digest per core, 128 bits per core (cores -> scheduler)
//   ret_att_bus : candidate that produced hash_bus, per core (cores -> scheduler)
// Handshake: there is no valid/ready pair on this bus. The cores accept a new
// att every cycle with no backpressure, and the scheduler decides on its own
// which hash outputs are meaningful by delaying a valid bit per core through
// a pipeline matching the core latency.
interface md5_crack_scheduler_if
  import md5_pkg::*;
#(
  parameter int N_CORES = 3
);
  logic [CAND_W*N_CORES-1:0]   att_bus;
  logic [DIGEST_W*N_CORES-1:0] hash_bus;
  logic [CAND_W*N_CORES-1:0]   ret_att_bus;

  modport master (output att_bus, input hash_bus, input ret_att_bus);
  modport slave  (input att_bus, output hash_bus, output ret_att_bus);
endinterface

// File: rtl/bcd_ascii_adder.sv
// Combinational adder for 8-digit ASCII decimal numbers.
//   a         : 8 ASCII digits, most significant digit in the top byte
//   inc       : increment 0..9 added to the least significant digit
//   sum       : a + inc, still ASCII, each byte keeps its upper nibble
//   carry_out : set when the sum wrapped past "99999999"
module bcd_ascii_adder
  import md5_pkg::*;
(
  input  logic [CAND_W-1:0] a,
  input  logic [3:0]        inc,
  output logic [CAND_W-1:0] sum,
  output logic              carry_out
);
  logic [4:0] dsum;
  logic [3:0] dig;
  logic [3:0] carry;

  // Carry ripples byte by byte; only the low nibble of each byte carries the
  // digit value, so the ASCII '3' nibble is simply passed through.
  always_comb begin
    sum   = '0;
    dsum  = '0;
    dig   = '0;
    carry = inc;
    for (int k = 0; k < 8; k++) begin
      dsum = {1'b0, a[8*k +: 4]} + {1'b0, carry};
      if (dsum > 5'd9) begin
        // dsum is 10..18; 4-bit wraparound of (dsum - 10) gives 0..8
        dig   = dsum[3:0] - 4'd10;
        carry = 4'd1;
      end else begin
        dig   = dsum[3:0];
        carry = 4'd0;
      end
      sum[8*k +: 8] = {a[8*k+4 +: 4], dig};
    end
    carry_out = carry[0];
  end
endmodule

// File: rtl/md5_crack_scheduler.sv
// Drives a bank of pipelined md5 cores through an ASCII decimal password
// search from "00000000" up to LAST_CAND, N_CORES candidates per cycle.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : pulse; begins a fresh search (ignored while busy)
//   abort         : back to IDLE; beats start and a simultaneous match
//   target_hash   : digest to find, captured on an accepted start
//   cores         : md5 core bus (att out, hash / returned att in)
//   busy          : searching (RUN or DRAIN)
//   found         : a match was reported, password is valid
//   exhausted     : every candidate was tried without a match
//   password      : matching candidate, latched
//   cycles        : RUN+DRAIN cycle count, saturating, frozen at the end
//   state_dbg     : current FSM state
module md5_crack_scheduler
  import md5_pkg::*;
#(
  parameter int                N_CORES   = 3,
  parameter int                PIPE_LAT  = DEFAULT_PIPE_LAT,
  parameter logic [CAND_W-1:0] LAST_CAND = "99999999"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DIGEST_W-1:0]   target_hash,
  md5_crack_scheduler_if.master cores,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [CAND_W-1:0]     password,
  output logic [31:0]           cycles,
  output sched_state_t          state_dbg
);
  localparam int DCW = $clog2(PIPE_LAT + 1);

  sched_state_t               state;
  logic [CAND_W-1:0]          base;
  logic [CAND_W-1:0]          base_next;
  logic                       base_ovf;
  logic [CAND_W*N_CORES-1:0]  cand;
  logic [N_CORES-1:0]         cand_ovf;
  logic [N_CORES-1:0]         cand_ok;
  logic [CAND_W*N_CORES-1:0]  att_q;
  logic [N_CORES-1:0]         vld_att;
  logic [N_CORES-1:0]         vpipe [PIPE_LAT];
  logic [DIGEST_W-1:0]        target_q;
  logic [DCW-1:0]             drain_cnt;
  logic [N_CORES-1:0]         hit;
  logic                       hit_any;
  logic [CAND_W-1:0]          hit_att;
  logic                       group_has_last;
  logic [31:0]                cycles_inc;

  assign cores.att_bus = att_q;
  assign state_dbg     = state;

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    bcd_ascii_adder u_cand_add (
      .a         (base),
      .inc       (4'(i)),
      .sum       (cand[CAND_W*i +: CAND_W]),
      .carry_out (cand_ovf[i])
    );
    // ASCII digits compare in the same order as their numeric values
    assign cand_ok[i] = !cand_ovf[i] && (cand[CAND_W*i +: CAND_W] <= LAST_CAND);
    assign hit[i] = vpipe[PIPE_LAT-1][i] &&
                    (cores.hash_bus[DIGEST_W*i +: DIGEST_W] == target_q);
  end

  bcd_ascii_adder u_base_add (
    .a         (base),
    .inc       (4'(N_CORES)),
    .sum       (base_next),
    .carry_out (base_ovf)
  );

  // The group containing LAST_CAND is the last one issued: either its top
  // candidate is masked, equals LAST_CAND, or the next base would wrap.
  assign group_has_last = !cand_ok[N_CORES-1] ||
                          (cand[CAND_W*(N_CORES-1) +: CAND_W] == LAST_CAND) ||
                          base_ovf;

  // Lowest core index wins: scan downwards so the last assignment is core 0.
  always_comb begin
    hit_any = 1'b0;
    hit_att = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_att = cores.ret_att_bus[CAND_W*i +: CAND_W];
      end
    end
  end

  assign cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
      password  <= '0;
      cycles    <= '0;
      base      <= ALL_ZERO_CAND;
      att_q     <= {N_CORES{ALL_ZERO_CAND}};
      vld_att   <= '0;
      target_q  <= '0;
      drain_cnt <= '0;
      for (int s = 0; s < PIPE_LAT; s++) vpipe[s] <= '0;
    end else begin
      // Valid pipeline shifts every cycle; stage 0 lines up with att_q.
      vpipe[0] <= vld_att;
      for (int s = 1; s < PIPE_LAT; s++) vpipe[s] <= vpipe[s-1];
      vld_att <= '0;

      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        found     <= 1'b0;
        exhausted <= 1'b0;
        cycles    <= '0;
        for (int s = 0; s < PIPE_LAT; s++) vpipe[s] <= '0;
      end else begin
        case (state)
          IDLE, FOUND, EXHAUSTED: begin
            if (state == IDLE) cycles <= '0;
            if (start) begin
              state     <= RUN;
              busy      <= 1'b1;
              found     <= 1'b0;
              exhausted <= 1'b0;
              cycles    <= '0;
              target_q  <= target_hash;
              base      <= ALL_ZERO_CAND;
              for (int s = 0; s < PIPE_LAT; s++) vpipe[s] <= '0;
            end
          end
          RUN: begin
            if (hit_any) begin
              state    <= FOUND;
              busy     <= 1'b0;
              found    <= 1'b1;
              password <= hit_att;
            end else begin
              att_q   <= cand;
              vld_att <= cand_ok;
              base    <= base_next;
              cycles  <= cycles_inc;
              if (group_has_last) begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end
          end
          DRAIN: begin
            if (hit_any) begin
              state    <= FOUND;
              busy     <= 1'b0;
              found    <= 1'b1;
              password <= hit_att;
            end else if (drain_cnt == DCW'(PIPE_LAT)) begin
              state     <= EXHAUSTED;
              busy      <= 1'b0;
              exhausted <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DCW'(1);
              cycles    <= cycles_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_md5_crack_scheduler.sv
module tb_md5_crack_scheduler;
  import md5_pkg::*;

  localparam int NC = 3;
  localparam int PL = 64;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (full range) ----------------
  logic                start, abort;
  logic [127:0]        target_hash;
  logic                busy, found, exhausted;
  logic [63:0]         password;
  logic [31:0]         cycles;
  sched_state_t        state_dbg;
  logic [63:0]         alias_c;
  logic                use_alias;

  md5_crack_scheduler_if #(.N_CORES(NC)) bus ();

  md5_crack_scheduler #(.N_CORES(NC), .PIPE_LAT(PL), .LAST_CAND("99999999")) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .target_hash(target_hash), .cores(bus),
    .busy(busy), .found(found), .exhausted(exhausted),
    .password(password), .cycles(cycles), .state_dbg(state_dbg)
  );

  // ---------------- second DUT (short range, exhaustion) ----------------
  logic                start_x, abort_x;
  logic [127:0]        target_x;
  logic                busy_x, found_x, exhausted_x;
  logic [63:0]         password_x;
  logic [31:0]         cycles_x;
  sched_state_t        state_dbg_x;
  logic                force_x;

  md5_crack_scheduler_if #(.N_CORES(NC)) bus_x ();

  md5_crack_scheduler #(.N_CORES(NC), .PIPE_LAT(PL), .LAST_CAND("00000007")) dut_x (
    .clk(clk), .reset(reset), .start(start_x), .abort(abort_x),
    .target_hash(target_x), .cores(bus_x),
    .busy(busy_x), .found(found_x), .exhausted(exhausted_x),
    .password(password_x), .cycles(cycles_x), .state_dbg(state_dbg_x)
  );

  // ---------------- behavioural md5 stand-in ----------------
  function automatic logic [127:0] fake(input logic [63:0] x);
    return {~x, x ^ 64'hDEAD_BEEF_CAFE_F00D};
  endfunction

  logic [64*NC-1:0] dl   [PL];
  logic [64*NC-1:0] dl_x [PL];

  always_ff @(posedge clk) begin
    dl[0]   <= bus.att_bus;
    dl_x[0] <= bus_x.att_bus;
    for (int s = 1; s < PL; s++) begin
      dl[s]   <= dl[s-1];
      dl_x[s] <= dl_x[s-1];
    end
  end

  assign bus.ret_att_bus   = dl[PL-1];
  assign bus_x.ret_att_bus = dl_x[PL-1];

  always_comb begin
    bus.hash_bus   = '0;
    bus_x.hash_bus = '0;
    for (int i = 0; i < NC; i++) begin
      if (use_alias && dl[PL-1][64*i +: 64] == alias_c)
        bus.hash_bus[128*i +: 128] = target_hash;
      else
        bus.hash_bus[128*i +: 128] = fake(dl[PL-1][64*i +: 64]);
      if (force_x)
        bus_x.hash_bus[128*i +: 128] = target_x;
      else
        bus_x.hash_bus[128*i +: 128] = fake(dl_x[PL-1][64*i +: 64]);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Digit monitor on the main DUT's issue stream
  logic        bad_digit;
  logic        seen99;
  logic [63:0] got100, got101;

  always @(negedge clk) begin
    if (busy && !reset) begin
      for (int b = 0; b < 8*NC; b++)
        if (bus.att_bus[8*b+4 +: 4] != 4'h3 || bus.att_bus[8*b +: 4] > 4'd9) bad_digit <= 1'b1;
      if (bus.att_bus[63:0] == "00000099") begin
        seen99 <= 1'b1;
        got100 <= bus.att_bus[127:64];
        got101 <= bus.att_bus[191:128];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_start_x();
    @(negedge clk);
    start_x = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] tgt;
    logic [63:0] alias_v;
    logic        use_al;
    logic [63:0] pwd;
    int          lat;
    int          cyc;
  } vec_t;

  vec_t vecs [6];
  int   lat;
  logic seen_flag;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; start_x = 1'b0; abort_x = 1'b0;
    target_hash = '0; target_x = '0; alias_c = '0; use_alias = 1'b0; force_x = 1'b0;
    bad_digit = 1'b0; seen99 = 1'b0; got100 = '0; got101 = '0;

    // found latency = 66 + group index, cycles = 65 + group index (N=3)
    vecs[0] = '{"00000005", 64'h0,       1'b0, "00000005", 67, 66};
    vecs[1] = '{"00000000", 64'h0,       1'b0, "00000000", 66, 65};
    vecs[2] = '{"00000010", 64'h0,       1'b0, "00000010", 69, 68};
    vecs[3] = '{"00000003", "00000005",  1'b1, "00000003", 67, 66};
    vecs[4] = '{"00000007", "00000008",  1'b1, "00000007", 68, 67};
    vecs[5] = '{"00000100", 64'h0,       1'b0, "00000100", 99, 98};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_found", 64'(found), 64'd0);
    check("rst_exh", 64'(exhausted), 64'd0);
    check("rst_pwd", password, 64'h0);
    check("rst_cycles", 64'(cycles), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    check("rst_att0", bus.att_bus[63:0], "00000000");
    check("rst_att2", bus.att_bus[191:128], "00000000");

    // Table-driven searches on the full-range DUT
    for (int r = 0; r < 6; r++) begin
      target_hash = fake(vecs[r].tgt);
      alias_c     = vecs[r].alias_v;
      use_alias   = vecs[r].use_al;
      pulse_start();
      lat = 0;
      for (int j = 1; j <= 200; j++) begin
        @(posedge clk); #1;
        if (found) begin lat = j; break; end
      end
      check("vec_latency", 64'(lat), 64'(vecs[r].lat));
      check("vec_password", password, vecs[r].pwd);
      check("vec_cycles", 64'(cycles), 64'(vecs[r].cyc));
      check("vec_busy", 64'(busy), 64'd0);
      check("vec_state", 64'(state_dbg), 64'(FOUND));
    end
    use_alias = 1'b0;

    check("carry_seen99", 64'(seen99), 64'd1);
    check("carry_100", got100, "00000100");
    check("carry_101", got101, "00000101");
    check("carry_no_colon", 64'(bad_digit), 64'd0);

    // Exhaustion: LAST_CAND = "00000007", target is the masked "00000008"
    target_x = fake("00000008");
    pulse_start_x();
    @(posedge clk); #1;
    check("exh_g0_c0", bus_x.att_bus[63:0], "00000000");
    check("exh_g0_c2", bus_x.att_bus[191:128], "00000002");
    @(posedge clk); #1;
    check("exh_g1_c0", bus_x.att_bus[63:0], "00000003");
    check("exh_g1_c2", bus_x.att_bus[191:128], "00000005");
    @(posedge clk); #1;
    check("exh_g2_c0", bus_x.att_bus[63:0], "00000006");
    check("exh_g2_c1", bus_x.att_bus[127:64], "00000007");
    check("exh_drain", 64'(state_dbg_x), 64'(DRAIN));
    lat = 0;
    for (int j = 4; j <= 200; j++) begin
      @(posedge clk); #1;
      if (exhausted_x || found_x) begin lat = j; break; end
    end
    check("exh_latency", 64'(lat), 64'd68);
    check("exh_flag", 64'(exhausted_x), 64'd1);
    check("exh_found", 64'(found_x), 64'd0);
    check("exh_busy", 64'(busy_x), 64'd0);
    check("exh_cycles", 64'(cycles_x), 64'd67);
    check("exh_att_hold", bus_x.att_bus[63:0], "00000006");

    // Reset while in DRAIN
    pulse_start_x();
    repeat (10) begin @(posedge clk); #1; end
    check("rd_in_drain", 64'(state_dbg_x), 64'(DRAIN));
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("rd_busy", 64'(busy_x), 64'd0);
    check("rd_exh", 64'(exhausted_x), 64'd0);
    check("rd_cycles", 64'(cycles_x), 64'd0);
    check("rd_pwd", password_x, 64'h0);
    check("rd_state", 64'(state_dbg_x), 64'(IDLE));
    check("rd_att", bus_x.att_bus[127:64], "00000000");
    force_x = 1'b1;
    seen_flag = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (found_x) seen_flag = 1'b1; end
    check("rd_no_match", 64'(seen_flag), 64'd0);
    force_x = 1'b0;

    // Abort 10 cycles into RUN with a match in flight
    target_hash = fake("00000005");
    pulse_start();
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_state", 64'(state_dbg), 64'(IDLE));
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_cycles", 64'(cycles), 64'd0);
    seen_flag = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (found) seen_flag = 1'b1; end
    check("ab_no_found", 64'(seen_flag), 64'd0);
    pulse_start();
    check("ab_restart_cycles", 64'(cycles), 64'd0);
    @(posedge clk); #1;
    check("ab_restart_c0", bus.att_bus[63:0], "00000000");
    check("ab_restart_c1", bus.att_bus[127:64], "00000001");
    lat = 0;
    for (int j = 2; j <= 200; j++) begin
      @(posedge clk); #1;
      if (found) begin lat = j; break; end
    end
    check("ab_restart_lat", 64'(lat), 64'd67);
    check("ab_restart_pwd", password, "00000005");

    // start during RUN is ignored; abort on the match cycle wins
    pulse_start();
    seen_flag = 1'b0;
    for (int j = 1; j <= 67; j++) begin
      @(posedge clk); #1;
      if (j == 19) start = 1'b1;
      if (j == 20) begin
        start = 1'b0;
        check("run_start_ignored", 64'(cycles), 64'd20);
      end
      if (found) seen_flag = 1'b1;
      if (j == 66) abort = 1'b1;
    end
    abort = 1'b0;
    check("abm_no_found", 64'(seen_flag), 64'd0);
    check("abm_state", 64'(state_dbg), 64'(IDLE));
    check("abm_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
